// File: rtl/rf_scoreboard_if.sv
// ID/WB-side signal bundle between the pipeline and the register-file write scoreboard.
// The master (pipeline) drives issue/retire/flush; the slave (scoreboard) returns the interlock.
interface rf_scoreboard_if #(
  parameter int unsigned TOT_W = 6
);
  logic             id_valid;
  logic             id_issue;
  logic             id_gr_we;
  logic [4:0]       id_dest;
  logic [4:0]       id_rs1;
  logic             id_rs1_used;
  logic [4:0]       id_rs2;
  logic             id_rs2_used;
  logic             rf_we;
  logic [4:0]       rf_waddr;
  logic             flush;
  logic             id_stall;
  logic             busy;
  logic [TOT_W-1:0] inflight_cnt;
  logic             sb_err;

  modport master (
    output id_valid, id_issue, id_gr_we, id_dest, id_rs1, id_rs1_used,
           id_rs2, id_rs2_used, rf_we, rf_waddr, flush,
    input  id_stall, busy, inflight_cnt, sb_err
  );

  modport slave (
    input  id_valid, id_issue, id_gr_we, id_dest, id_rs1, id_rs1_used,
           id_rs2, id_rs2_used, rf_we, rf_waddr, flush,
    output id_stall, busy, inflight_cnt, sb_err
  );
endinterface

// File: rtl/rf_scoreboard.sv
// Register-file write scoreboard: per-GPR pending-write counters from ID issue to WB commit,
// driving the ID read-after-write / counter-full interlock.
module rf_scoreboard #(
  parameter int unsigned NREG  = 32,
  parameter int unsigned CNT_W = 2,
  parameter int unsigned TOT_W = 6
) (
  input logic          clk,
  input logic          resetn,
  rf_scoreboard_if.slave sb
);

  localparam logic [CNT_W-1:0] PendMax = '1;

  // r0 is hard-wired zero, so it has no counter at all.
  logic [CNT_W-1:0] pend_q [1:NREG-1];
  logic [CNT_W-1:0] pend_d [1:NREG-1];
  logic [TOT_W-1:0] tot_q, tot_d;
  logic             err_q, err_d;

  logic             inc, dec, same_reg;
  logic             inc_ok, dec_ok, ovf, udf;
  logic [CNT_W-1:0] dest_cnt, waddr_cnt, rs1_cnt, rs2_cnt;
  logic             haz_rs1, haz_rs2, full_dest;

  // Counter lookups; address 0 (and anything beyond NREG-1) reads as zero.
  always_comb begin
    dest_cnt  = '0;
    waddr_cnt = '0;
    rs1_cnt   = '0;
    rs2_cnt   = '0;
    for (int unsigned i = 1; i < NREG; i++) begin
      if (sb.id_dest  == 5'(i)) dest_cnt  = pend_q[i];
      if (sb.rf_waddr == 5'(i)) waddr_cnt = pend_q[i];
      if (sb.id_rs1   == 5'(i)) rs1_cnt   = pend_q[i];
      if (sb.id_rs2   == 5'(i)) rs2_cnt   = pend_q[i];
    end
  end

  assign inc      = sb.id_issue & sb.id_gr_we & (sb.id_dest != 5'd0);
  assign dec      = sb.rf_we & (sb.rf_waddr != 5'd0);
  // Issue and retire of the same register cancel; only a retire of an idle counter is an error.
  assign same_reg = inc & dec & (sb.id_dest == sb.rf_waddr);
  assign ovf      = inc & ~same_reg & (dest_cnt == PendMax);
  assign udf      = dec & (waddr_cnt == '0);
  assign inc_ok   = inc & ~same_reg & ~ovf;
  assign dec_ok   = dec & ~same_reg & ~udf;

  always_comb begin
    pend_d = pend_q;
    tot_d  = tot_q;
    err_d  = err_q;
    if (sb.flush) begin
      for (int unsigned i = 1; i < NREG; i++) begin
        pend_d[i] = '0;
      end
      tot_d = '0;
    end else begin
      for (int unsigned i = 1; i < NREG; i++) begin
        if (inc_ok && (sb.id_dest == 5'(i)))  pend_d[i] = pend_q[i] + CNT_W'(1);
        if (dec_ok && (sb.rf_waddr == 5'(i))) pend_d[i] = pend_q[i] - CNT_W'(1);
      end
      tot_d = tot_q + TOT_W'(inc_ok) - TOT_W'(dec_ok);
      err_d = err_q | ovf | udf;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 1; i < NREG; i++) begin
        pend_q[i] <= '0;
      end
      tot_q <= '0;
      err_q <= 1'b0;
    end else begin
      for (int unsigned i = 1; i < NREG; i++) begin
        pend_q[i] <= pend_d[i];
      end
      tot_q <= tot_d;
      err_q <= err_d;
    end
  end

  // No WB->ID bypass: a retiring producer still stalls its consumer for that cycle.
  assign haz_rs1   = sb.id_rs1_used & (sb.id_rs1 != 5'd0) & (rs1_cnt != '0);
  assign haz_rs2   = sb.id_rs2_used & (sb.id_rs2 != 5'd0) & (rs2_cnt != '0);
  assign full_dest = sb.id_gr_we & (sb.id_dest != 5'd0) & (dest_cnt == PendMax);

  assign sb.id_stall     = sb.id_valid & (haz_rs1 | haz_rs2 | full_dest);
  assign sb.busy         = (tot_q != '0);
  assign sb.inflight_cnt = tot_q;
  assign sb.sb_err       = err_q;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Self-checking bench for rf_scoreboard: directed vector table, hand sequences for reset and
// underflow, then randomized traffic against a counting reference model.
module tb_rf_scoreboard;

  localparam int MAXP = 3;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  rf_scoreboard_if #(.TOT_W(6)) sb_bus ();

  rf_scoreboard #(.NREG(32), .CNT_W(2), .TOT_W(6)) dut (
    .clk    (clk),
    .resetn (resetn),
    .sb     (sb_bus)
  );

  int checks = 0;
  int errors = 0;
  int pend_m [32];
  int err_m;

  typedef struct {
    int v, iss, we, d, r1, u1, r2, u2, rwe, wa, fl;
    int s, b, c, e;
  } vec_t;
  vec_t tbl [24];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input int v, input int iss, input int we, input int d, input int r1,
                       input int u1, input int r2, input int u2, input int rwe, input int wa,
                       input int fl);
    sb_bus.id_valid    = v[0];
    sb_bus.id_issue    = iss[0];
    sb_bus.id_gr_we    = we[0];
    sb_bus.id_dest     = 5'(d);
    sb_bus.id_rs1      = 5'(r1);
    sb_bus.id_rs1_used = u1[0];
    sb_bus.id_rs2      = 5'(r2);
    sb_bus.id_rs2_used = u2[0];
    sb_bus.rf_we       = rwe[0];
    sb_bus.rf_waddr    = 5'(wa);
    sb_bus.flush       = fl[0];
  endtask

  function automatic int tot_m();
    int s = 0;
    for (int i = 0; i < 32; i++) s += pend_m[i];
    return s;
  endfunction

  function automatic int stall_m();
    int h1, h2, f;
    h1 = (sb_bus.id_rs1_used && sb_bus.id_rs1 != 0 && pend_m[sb_bus.id_rs1] != 0) ? 1 : 0;
    h2 = (sb_bus.id_rs2_used && sb_bus.id_rs2 != 0 && pend_m[sb_bus.id_rs2] != 0) ? 1 : 0;
    f  = (sb_bus.id_gr_we && sb_bus.id_dest != 0 && pend_m[sb_bus.id_dest] == MAXP) ? 1 : 0;
    return (sb_bus.id_valid && (h1 || h2 || f)) ? 1 : 0;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) pend_m[i] = 0;
    err_m = 0;
  endfunction

  // Clock-edge effect of the current inputs on the model.
  function automatic void model_edge();
    int d, a;
    bit inc, dec;
    d   = int'(sb_bus.id_dest);
    a   = int'(sb_bus.rf_waddr);
    inc = sb_bus.id_issue && sb_bus.id_gr_we && d != 0;
    dec = sb_bus.rf_we && a != 0;
    if (sb_bus.flush) begin
      for (int i = 0; i < 32; i++) pend_m[i] = 0;
    end else if (inc && dec && d == a) begin
      if (pend_m[a] == 0) err_m = 1;
    end else begin
      if (inc) begin
        if (pend_m[d] == MAXP) err_m = 1;
        else pend_m[d]++;
      end
      if (dec) begin
        if (pend_m[a] == 0) err_m = 1;
        else pend_m[a]--;
      end
    end
  endfunction

  task automatic check_outs(input string tag);
    chk({tag, " id_stall"}, int'(sb_bus.id_stall), stall_m());
    chk({tag, " busy"}, int'(sb_bus.busy), (tot_m() != 0) ? 1 : 0);
    chk({tag, " inflight_cnt"}, int'(sb_bus.inflight_cnt), tot_m());
    chk({tag, " sb_err"}, int'(sb_bus.sb_err), err_m);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_clear();
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //           v iss we  d r1 u1 r2 u2 rwe wa fl   s  b  c  e
    tbl[0]  = '{1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0,  1, 1, 1, 0};
    tbl[2]  = '{1, 0, 0, 0, 5, 1, 0, 0, 1, 5, 0,  1, 1, 1, 0};
    tbl[3]  = '{1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0};
    tbl[4]  = '{1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0};
    tbl[5]  = '{1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0,  0, 0, 0, 0};
    tbl[6]  = '{1, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0};
    tbl[7]  = '{1, 1, 1, 7, 0, 0, 0, 0, 1, 7, 0,  0, 1, 1, 0};
    tbl[8]  = '{1, 1, 1, 9, 0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0};
    tbl[9]  = '{1, 1, 1, 7, 0, 0, 0, 0, 1, 9, 0,  0, 1, 2, 0};
    tbl[10] = '{1, 0, 0, 0, 7, 1, 9, 1, 0, 0, 0,  1, 1, 2, 0};
    tbl[11] = '{1, 0, 0, 0, 0, 0, 9, 1, 0, 0, 0,  0, 1, 2, 0};
    tbl[12] = '{1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0,  0, 1, 2, 0};
    tbl[13] = '{1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0,  0, 1, 3, 0};
    tbl[14] = '{1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0,  0, 1, 4, 0};
    tbl[15] = '{1, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0,  1, 1, 5, 0};
    tbl[16] = '{1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0,  1, 1, 5, 0};
    tbl[17] = '{1, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0,  1, 1, 5, 1};
    tbl[18] = '{1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0,  0, 1, 5, 1};
    tbl[19] = '{1, 1, 1, 4, 0, 0, 0, 0, 0, 0, 0,  0, 1, 6, 1};
    tbl[20] = '{1, 1, 1, 4, 0, 0, 0, 0, 0, 0, 0,  0, 1, 7, 1};
    tbl[21] = '{1, 1, 1, 6, 0, 0, 0, 0, 1, 7, 1,  0, 1, 8, 1};
    tbl[22] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1};
    tbl[23] = '{1, 0, 1, 4, 2, 1, 3, 1, 0, 0, 0,  0, 0, 0, 1};

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_clear();
    #1;
    chk("reset id_stall", int'(sb_bus.id_stall), 0);
    chk("reset busy", int'(sb_bus.busy), 0);
    chk("reset inflight_cnt", int'(sb_bus.inflight_cnt), 0);
    chk("reset sb_err", int'(sb_bus.sb_err), 0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    for (int n = 0; n < 24; n++) begin
      drive(tbl[n].v, tbl[n].iss, tbl[n].we, tbl[n].d, tbl[n].r1, tbl[n].u1, tbl[n].r2,
            tbl[n].u2, tbl[n].rwe, tbl[n].wa, tbl[n].fl);
      #1;
      chk($sformatf("vec%0d id_stall", n), int'(sb_bus.id_stall), tbl[n].s);
      chk($sformatf("vec%0d busy", n), int'(sb_bus.busy), tbl[n].b);
      chk($sformatf("vec%0d inflight_cnt", n), int'(sb_bus.inflight_cnt), tbl[n].c);
      chk($sformatf("vec%0d sb_err", n), int'(sb_bus.sb_err), tbl[n].e);
      step();
    end

    // Underflow on an idle register sets the sticky error.
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
    #1;
    chk("udf before sb_err", int'(sb_bus.sb_err), 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("udf after sb_err", int'(sb_bus.sb_err), 1);
    chk("udf after inflight_cnt", int'(sb_bus.inflight_cnt), 0);

    // Asynchronous reset with pend[5]=2 clears outputs between clock edges.
    do_reset();
    drive(1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    drive(1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0);
    #1;
    chk("pre-areset id_stall", int'(sb_bus.id_stall), 1);
    chk("pre-areset inflight_cnt", int'(sb_bus.inflight_cnt), 2);
    resetn = 1'b0;
    #1;
    chk("areset id_stall", int'(sb_bus.id_stall), 0);
    chk("areset busy", int'(sb_bus.busy), 0);
    chk("areset inflight_cnt", int'(sb_bus.inflight_cnt), 0);
    model_clear();
    do_reset();

    // Randomized traffic, periodically reset so the sticky error stays informative.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      int v, we, d, r1, u1, r2, u2, rwe, wa, fl, iss, found, st;
      if (cyc % 250 == 249) do_reset();
      v  = int'($urandom_range(3) != 0);
      we = int'($urandom_range(3) != 0);
      d  = int'($urandom_range(7));
      r1 = int'($urandom_range(7));
      u1 = int'($urandom_range(1));
      r2 = int'($urandom_range(7));
      u2 = int'($urandom_range(1));
      fl = int'($urandom_range(60) == 0);
      found = 0;
      wa = 0;
      if ($urandom_range(3) != 0) begin
        st = int'($urandom_range(31));
        for (int k = 0; k < 32; k++) begin
          if (found == 0 && pend_m[(st + k) % 32] > 0) begin
            wa = (st + k) % 32;
            found = 1;
          end
        end
      end
      if (found != 0) rwe = int'($urandom_range(2) != 0);
      else begin
        rwe = int'($urandom_range(7) == 0);
        wa  = int'($urandom_range(7));
      end
      drive(v, 0, we, d, r1, u1, r2, u2, rwe, wa, fl);
      if (v != 0) begin
        if (stall_m() != 0) iss = int'($urandom_range(31) == 0);
        else iss = int'($urandom_range(1));
      end else iss = 0;
      sb_bus.id_issue = iss[0];
      #1;
      check_outs($sformatf("rnd%0d", cyc));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_scoreboard.md
Name: rf_scoreboard

Overview:
- Register-file write scoreboard for the 5-stage pipeline.
- Tracks GPR destinations in flight from ID issue to WB commit.
- Drives the ID-stage interlock (read-after-write and pending-count overflow) that holds ID until the producer has written the register file.
- Sits beside ID: issue events come from the ID->EX handshake; retire events are the WB register-file write signals (rf_we / rf_waddr).

Parameters:
- NREG, 32, number of architectural GPRs tracked; r0 is never tracked.
- CNT_W, 2, width of each per-register pending counter; max pending = 2^CNT_W-1.
- TOT_W, 6, width of the total in-flight counter.

Ports:
- clk  input  1  pipeline clock
- resetn  input  1  asynchronous active-low reset
- id_valid  input  1  ID stage holds a valid instruction
- id_issue  input  1  ID->EX handshake fires this cycle (ID valid, ready_go, EX allow_in)
- id_gr_we  input  1  ID instruction writes a GPR
- id_dest  input  5  ID destination register
- id_rs1  input  5  ID source register 1
- id_rs1_used  input  1  source 1 is read
- id_rs2  input  5  ID source register 2
- id_rs2_used  input  1  source 2 is read
- rf_we  input  1  WB register-file write enable (already qualified by WB valid)
- rf_waddr  input  5  WB write address
- flush  input  1  pipeline flush: all EX/MEM/WB contents discarded
- id_stall  output  1  ID must not issue this cycle
- busy  output  1  any register pending
- inflight_cnt  output  TOT_W  total pending writes
- sb_err  output  1  sticky protocol-error flag

Behaviour:
- State: pend[1..NREG-1] (CNT_W bits each), tot (TOT_W bits), err (1 bit). All registered; all outputs are combinational from this state plus ID inputs.
- Reset (resetn=0, asynchronous): all pend=0, tot=0, err=0. Hence id_stall=0, busy=0, inflight_cnt=0, sb_err=0 while in reset.
- Reset mid-operation clears all state immediately, without waiting for a clock edge.
- Issue event: inc = id_issue & id_gr_we & (id_dest!=0).
- Retire event: dec = rf_we & (rf_waddr!=0).
- Per-register update at posedge:
  - inc only: +1
  - dec only: -1
  - inc and dec on the same register: unchanged
  - inc and dec on different registers: each updated independently
- tot tracks the sum of all pend values: +1 on inc, -1 on dec, unchanged when both occur.
- Overflow: inc while pend[id_dest] is at max suppresses the increment and sets err. tot is still updated consistently with the actual pend change.
- Underflow: dec while pend[rf_waddr]==0 ignores the decrement and sets err.
- err is cleared only by reset.
- id_stall = id_valid & (H1 | H2 | F), where:
  - H1 = id_rs1_used & id_rs1!=0 & pend[id_rs1]!=0
  - H2 = id_rs2_used & id_rs2!=0 & pend[id_rs2]!=0
  - F = id_gr_we & id_dest!=0 & pend[id_dest]==max
- No same-cycle bypass: a WB retire of rs1/rs2 in cycle N does not clear id_stall in cycle N. The stall drops in N+1 (register-file write then visible). One-cycle penalty accepted.
- WAW with no source dependency does not stall until the counter is full.
- id_issue is gated externally by ~id_stall. id_issue with id_stall=1 is a protocol violation: the increment still applies under the normal rules; no extra err condition is defined.
- flush: at posedge, all pend=0 and tot=0, overriding same-cycle inc and dec. err is unchanged.
- The instruction in ID at flush is treated as not issued.
- busy = (tot!=0).
- inflight_cnt = tot.
- Latency: the issue/retire effect is visible on outputs one cycle after the event edge.

Test Plan:
- Reset, then release: id_stall=0, busy=0, inflight_cnt=0, sb_err=0.
  - Assert resetn=0 mid-run with pend[5]=2: all outputs clear without a clock edge.
- Issue r5 (gr_we=1) at cycle 0, then ID presents rs1=5, rs1_used=1:
  - id_stall=1 in cycles 1..k.
  - rf_we=1, rf_waddr=5 at cycle k: id_stall still 1 in k, 0 in k+1; inflight_cnt 1 -> 0.
- Source/destination r0: issue dest=0, then rs1=0 -> no stall, inflight_cnt stays 0.
  - rf_we with rf_waddr=0 -> no change, sb_err=0.
- Same cycle issue dest=7 and retire r7 with pend[7]=1: pend[7] stays 1, inflight_cnt unchanged.
  - Repeat with retire r9 (pend[9]=1): pend[7]=2, pend[9]=0, inflight_cnt unchanged.
- Issue dest=3 three times: next ID dest=3 -> id_stall=1 (full).
  - Forced id_issue leaves pend[3]=3 and sets sb_err=1.
  - Retire r3 when pend[3]=0 also sets sb_err=1.
- Flush with pend[2]=1, pend[4]=2, and same-cycle issue dest=6: next cycle all pend=0, inflight_cnt=0, busy=0, sb_err unchanged.
